// File: rtl/mem_requester.sv
// mem_requester
//   Initiator for the 16-bit word memory port. Accepts single-word writes and
//   burst reads from the core over a valid/ready request channel. It drives
//   mode/address/data onto the memory and returns read words over a
//   valid/ready response channel.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   req_valid/ready   request handshake
//   req_write         1 = single-word write, 0 = burst read
//   req_addr          start word address
//   req_wdata         write data
//   req_len           read burst length (0 -> 1, clamped to MAX_BURST)
//   rsp_valid/ready   response handshake
//   rsp_data/last     read word / final word of burst
//   wr_done           one-cycle pulse after the write cycle
//   busy              high whenever the block is not idle
//   mem_mode          2'b00 none, 2'b01 write, 2'b10 read
//   mem_addr          memory address (holds last value when idle)
//   mem_wdata         memory data_in (zero unless writing)
//   mem_rdata         memory data_out
module mem_requester #(
  parameter int READ_LATENCY = 1,  // legal 1..7
  parameter int MAX_BURST    = 4   // legal 1..7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [2:0]  req_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_last,
  output logic        wr_done,
  output logic        busy,
  output logic [1:0]  mem_mode,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_READ  = 2'b10;

  // Wait counter counts down to zero; the capture happens on the zero cycle.
  localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY - 1);
  localparam logic [2:0] MAX_LEN   = 3'(MAX_BURST);

  state_t      state_r;
  logic [2:0]  wait_cnt_r;
  logic [2:0]  beats_left_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [15:0] rsp_data_r;
  logic        rsp_last_r;
  logic        wr_done_r;
  logic        busy_r;
  logic [1:0]  mem_mode_r;
  logic [15:0] mem_addr_r;
  logic [15:0] mem_wdata_r;
  logic [2:0]  len_eff_s;

  // Normalise the requested burst length: 0 means one word, cap at MAX_BURST.
  always_comb begin
    len_eff_s = req_len;
    if (req_len == 3'd0) begin
      len_eff_s = 3'd1;
    end else if (req_len > MAX_LEN) begin
      len_eff_s = MAX_LEN;
    end else begin
      len_eff_s = req_len;
    end
  end

  // Request sequencer: state, memory port drive and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      wait_cnt_r   <= 3'd0;
      beats_left_r <= 3'd0;
      req_ready_r  <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= 16'h0000;
      rsp_last_r   <= 1'b0;
      wr_done_r    <= 1'b0;
      busy_r       <= 1'b0;
      mem_mode_r   <= MODE_NONE;
      mem_addr_r   <= 16'h0000;
      mem_wdata_r  <= 16'h0000;
    end else begin
      wr_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // req_ready_r is low for one cycle after reset, so nothing is
          // accepted until it has been presented high.
          if (req_valid && req_ready_r) begin
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            mem_addr_r  <= req_addr;
            if (req_write) begin
              state_r     <= ST_WRITE;
              mem_mode_r  <= MODE_WRITE;
              mem_wdata_r <= req_wdata;
            end else begin
              state_r      <= ST_READ;
              mem_mode_r   <= MODE_READ;
              mem_wdata_r  <= 16'h0000;
              beats_left_r <= len_eff_s;
              wait_cnt_r   <= WAIT_INIT;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end

        ST_WRITE: begin
          // The memory takes the word on this edge; report it next cycle.
          state_r     <= ST_IDLE;
          mem_mode_r  <= MODE_NONE;
          mem_wdata_r <= 16'h0000;
          wr_done_r   <= 1'b1;
          busy_r      <= 1'b0;
          req_ready_r <= 1'b1;
        end

        ST_READ: begin
          if (wait_cnt_r == 3'd0) begin
            rsp_data_r  <= mem_rdata;
            rsp_valid_r <= 1'b1;
            rsp_last_r  <= (beats_left_r == 3'd1);
            mem_mode_r  <= MODE_NONE;
            state_r     <= ST_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_last_r  <= 1'b0;
            if (beats_left_r > 3'd1) begin
              // Next beat: address wraps naturally at 16 bits.
              beats_left_r <= beats_left_r - 3'd1;
              mem_addr_r   <= mem_addr_r + 16'd1;
              mem_mode_r   <= MODE_READ;
              wait_cnt_r   <= WAIT_INIT;
              state_r      <= ST_READ;
            end else begin
              beats_left_r <= 3'd0;
              state_r      <= ST_IDLE;
              busy_r       <= 1'b0;
              req_ready_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_RESP;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          mem_mode_r  <= MODE_NONE;
          mem_wdata_r <= 16'h0000;
          rsp_valid_r <= 1'b0;
          rsp_last_r  <= 1'b0;
          busy_r      <= 1'b0;
          req_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_last  = rsp_last_r;
  assign wr_done   = wr_done_r;
  assign busy      = busy_r;
  assign mem_mode  = mem_mode_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule
